// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the transmitter arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10
    } arb_state_t;

    localparam int NREQ_DEF         = 4;
    localparam int FRAME_CYCLES_DEF = 12;
    localparam int BYTE_W           = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of valid searching upward from ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int IW = $clog2(NREQ);

    int            k;
    logic [IW-1:0] idx;

    // Walk the requesters starting at ptr; the first valid one wins
    always_comb begin
        any       = 1'b0;
        grant     = '0;
        grant_idx = '0;
        k         = 0;
        idx       = '0;
        for (int off = 0; off < NREQ; off++) begin
            k = int'(ptr) + off;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            idx = IW'(k);
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial transmitter between NREQ sources.
// Latency: accept at t, tx_send at t+1, WAIT for FRAME_CYCLES, next accept no earlier than t+FRAME_CYCLES+2.
// Backpressure: req_ready only pulses in IDLE; requests during SEND/WAIT stay pending at the source.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NREQ         = NREQ_DEF,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_send,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     wait_cnt;

    logic              pick_any;
    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic [BYTE_W-1:0] pick_dat;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .any       (pick_any),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // Select the winner's byte; grant is one-hot so an OR of masked lanes suffices
    always_comb begin
        pick_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                pick_dat = pick_dat | req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs; ready is only offered while idle
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_send   = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = pick_grant;
                if (pick_any) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_send   = 1'b1;
                busy      = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted byte, advance the round-robin pointer, run the frame timer
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            tx_data  <= '0;
            grant_id <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        tx_data  <= pick_dat;
                        grant_id <= pick_idx;
                        ptr      <= (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
                    end
                end
                ST_SEND: begin
                    wait_cnt <= CNT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter at NREQ=4, FRAME_CYCLES=12.
// Latency: inputs driven 2 time units after the rising edge, outputs sampled 1 unit later.
// Backpressure: bench sources drop req_valid after seeing their req_ready pulse.
module tb_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int FRAME = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_send;
    logic [7:0]        tx_data;
    logic              busy;
    logic [1:0]        grant_id;

    int total = 0;
    int bad   = 0;

    tx_arbiter #(
        .NREQ         (NREQ),
        .FRAME_CYCLES (FRAME)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, nsend, unstable, ng, ns, k, viol, ne, low, minlow;
        int          order[8];
        int          st[8];
        int          rcnt[4];
        logic [7:0]  sd[8];
        logic [7:0]  eb[4];
        logic [3:0]  mask;
        logic        prev;

        // ---- reset ----
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tick();
        tick();
        chk("rst_ready",    32'(req_ready), 32'h0);
        chk("rst_tx_send",  32'(tx_send),   32'h0);
        chk("rst_tx_data",  32'(tx_data),   32'h0);
        chk("rst_busy",     32'(busy),      32'h0);
        chk("rst_grant_id", 32'(grant_id),  32'h0);
        rst = 1'b1;

        // ---- single request from requester 2 ----
        req_data  = 32'h44_A5_22_11;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_busy_pre", 32'(busy), 32'h0);
        tick();
        req_valid = '0;
        #1;
        chk("single_send",     32'(tx_send),   32'h1);
        chk("single_data",     32'(tx_data),   32'hA5);
        chk("single_grant_id", 32'(grant_id),  32'h2);
        chk("single_ready_off", 32'(req_ready), 32'h0);
        n = 0; nsend = 0; unstable = 0;
        while (busy && n < 40) begin
            n++;
            if (tx_send) nsend++;
            if (tx_data !== 8'hA5) unstable++;
            tick();
        end
        chk("single_busy_cycles", 32'(n), 32'd13);
        chk("single_send_count",  32'(nsend), 32'd1);
        chk("single_data_stable", 32'(unstable), 32'd0);
        chk("single_data_idle",   32'(tx_data), 32'hA5);

        // ---- wrap: ptr is 3, requesters 0 and 3 pending ----
        req_data  = 32'h44_33_22_11;
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("wrap_grant3", 32'(grant_id), 32'h3);
        chk("wrap_data3",  32'(tx_data),  32'h44);
        chk("wrap_send3",  32'(tx_send),  32'h1);
        chk("wrap_ready_busy", 32'(req_ready), 32'h0);
        wait_idle();
        chk("wrap_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("wrap_grant0", 32'(grant_id), 32'h0);
        chk("wrap_data0",  32'(tx_data),  32'h11);
        wait_idle();

        // ---- all four held valid from reset ----
        rst = 1'b0;
        tick();
        rst       = 1'b1;
        req_data  = 32'h44_33_22_11;
        req_valid = 4'hF;
        ng = 0; ns = 0;
        for (int i = 0; i < 4; i++) rcnt[i] = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            #1;
            mask = req_ready;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    rcnt[i]++;
                    if (ng < 8) order[ng] = i;
                    ng++;
                end
            end
            if (tx_send) begin
                if (ns < 8) begin
                    st[ns] = cyc;
                    sd[ns] = tx_data;
                end
                ns++;
            end
            tick();
            req_valid = req_valid & ~mask;
        end
        chk("all_grants", 32'(ng), 32'd4);
        chk("all_sends",  32'(ns), 32'd4);
        chk("all_first_send_cycle", 32'(st[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all_order%0d", i), 32'(order[i]), 32'(i));
            chk($sformatf("all_data%0d", i),  32'(sd[i]),    32'(8'h11 * (i + 1)));
            chk($sformatf("all_rcnt%0d", i),  32'(rcnt[i]),  32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("all_spacing%0d", i), 32'(st[i+1] - st[i]), 32'd14);
        end

        // ---- reset in the middle of WAIT ----
        req_valid = 4'b0100;
        #1;
        chk("rw_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1010;
        #1;
        chk("rw_send", 32'(tx_send), 32'h1);
        repeat (5) tick();
        chk("rw_busy_before", 32'(busy), 32'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rw_busy",     32'(busy),      32'h0);
        chk("rw_tx_send",  32'(tx_send),   32'h0);
        chk("rw_tx_data",  32'(tx_data),   32'h0);
        chk("rw_grant_id", 32'(grant_id),  32'h0);
        chk("rw_ready1",   32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        chk("rw_regrant_id", 32'(grant_id), 32'h1);
        chk("rw_regrant_send", 32'(tx_send), 32'h1);
        chk("rw_regrant_data", 32'(tx_data), 32'h22);
        wait_idle();

        // ---- withdrawn request during WAIT ----
        req_data  = 32'h44_33_22_5A;
        req_valid = 4'b0001;
        #1;
        chk("wd_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        k = 0; viol = 0;
        while (busy && k < 40) begin
            if (req_ready != '0) viol++;
            if (tx_send && k != 0) viol++;
            if (!tx_send && k == 0) viol++;
            if (tx_data !== 8'h5A) viol++;
            k++;
            tick();
            if (k == 3) req_valid = 4'b0010;
            if (k == 8) req_valid = '0;
            #1;
        end
        chk("wd_busy_cycles", 32'(k), 32'd13);
        chk("wd_violations",  32'(viol), 32'd0);
        viol = 0;
        repeat (5) begin
            if (tx_send || req_ready != '0) viol++;
            tick();
        end
        chk("wd_idle_quiet", 32'(viol), 32'd0);

        // ---- back-to-back bytes 00, FF, 3C (ptr is 1) ----
        req_data  = 32'h00_FF_00_3C;
        req_valid = 4'b0111;
        prev = 1'b0; ne = 0; low = 0; minlow = 1000;
        for (int cyc = 0; cyc < 50; cyc++) begin
            #1;
            mask = req_ready;
            if (tx_send && !prev) begin
                if (ne < 4) eb[ne] = tx_data;
                if (ne > 0 && low < minlow) minlow = low;
                ne++;
            end
            if (!tx_send) low++;
            else low = 0;
            prev = tx_send;
            tick();
            req_valid = req_valid & ~mask;
        end
        chk("b2b_edges",  32'(ne),    32'd3);
        chk("b2b_byte0",  32'(eb[0]), 32'h00);
        chk("b2b_byte1",  32'(eb[1]), 32'hFF);
        chk("b2b_byte2",  32'(eb[2]), 32'h3C);
        chk("b2b_minlow", 32'(minlow), 32'(FRAME + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares one 8-bit serial transmitter between `NREQ` byte sources. Accepts a byte from one requester at a time under round-robin priority and issues a single-cycle `tx_send` pulse with the byte on `tx_data`. Then holds off for a fixed frame interval so the transmitter finishes its frame and sees `tx_send` low before the next rising edge. Sits between the byte producers and the transmitter FSM; `tx_send`/`tx_data` connect directly to the transmitter's `send`/`data`.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `FRAME_CYCLES`, 12: cycles spent in WAIT after each send pulse; must be ≥ 11; the transmitter frame is 11 cycles.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `req_valid` input NREQ: requester i has a byte pending.
- `req_data` input 8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_ready` output NREQ: one-hot pulse; bit i high for one cycle when the byte of requester i is accepted.
- `tx_send` output 1: send pulse to the transmitter.
- `tx_data` output 8: byte to the transmitter.
- `busy` output 1: high in SEND and WAIT.
- `grant_id` output $clog2(NREQ): index of the last accepted requester.

## Operation
- States: IDLE, SEND, WAIT.
- **IDLE**
  - If any `req_valid` bit is set, pick winner w: the first set bit searching upward from pointer `ptr`, wrapping modulo NREQ.
  - Same cycle: `req_ready[w]`=1. A transfer happens when `req_valid[w]` and `req_ready[w]` are both high.
  - Next edge: latch `req_data[w]` into `tx_data`; `grant_id`←w; `ptr`←(w+1) mod NREQ; go to SEND.
  - If no request is pending, stay in IDLE; `ptr` is unchanged.
- **SEND**
  - `tx_send`=1 for exactly this one cycle.
  - Load wait counter with FRAME_CYCLES−1; go to WAIT.
- **WAIT**
  - `tx_send`=0; counter decrements each cycle.
  - At count 0, go to IDLE.
- Requester handshake:
  - A requester must hold `req_valid` and `req_data` stable until it sees its `req_ready` pulse.
  - Dropping `req_valid` before `req_ready` withdraws the request with no side effects.
- `tx_data` is held stable from the latch edge through the end of WAIT, and keeps its value in IDLE.
- `req_ready` is never asserted in SEND or WAIT. Requests arriving then are simply pending.
- Simultaneous requests: exactly one is granted per frame, in round-robin order. No requester waits more than NREQ−1 frames while its valid is held.
- Reset (`rst`=0 at an edge), including mid-frame:
  - state←IDLE, `ptr`←0, `tx_data`←0, `grant_id`←0, counter←0.
  - `tx_send`, `busy`, `req_ready` go to 0.
  - An aborted frame is not retried. The transmitter shares the same reset.

## Timing
- `req_ready`, `tx_send` and `busy` are decoded from the registered state. `req_ready` additionally depends combinationally on `req_valid` and `ptr`; there is no other input-to-output path.
- Latency: accept at cycle t (IDLE, `req_ready` high); `tx_send` high at t+1; WAIT covers t+2..t+1+FRAME_CYCLES; IDLE at t+2+FRAME_CYCLES.
- Minimum spacing between `tx_send` pulses: FRAME_CYCLES+2 cycles (14 at default).
- `tx_send` is low for at least FRAME_CYCLES+1 consecutive cycles between pulses, so each pulse is a clean rising edge for the transmitter's edge detector.
- Reset values of all outputs: `req_ready`=0, `tx_send`=0, `tx_data`=8'h00, `busy`=0, `grant_id`=0.

## Structure
- Package `tx_arb_pkg`: state encoding (IDLE=2'b00, SEND=2'b01, WAIT=2'b10) and the default constants NREQ_DEF=4 and FRAME_CYCLES_DEF=12.
- Sub-module `rr_pick`: parameterised by NREQ. Combinational first-set-bit search from `ptr` with wrap. Outputs `any`, one-hot `grant` and `grant_idx`. `ptr` lives in `tx_arbiter`.
- Counter width: $clog2(FRAME_CYCLES).

## Test plan
- Single request: `req_valid`=4'b0100, `req_data[23:16]`=8'hA5 → `req_ready`=4'b0100 for one cycle; next cycle `tx_send`=1 with `tx_data`=8'hA5; `busy` high for 13 cycles; `grant_id`=2.
- All four requesters held valid for 4 frames, from reset → grants in order 0,1,2,3; `tx_send` pulses exactly 14 cycles apart; each `req_ready` bit pulses once.
- Round-robin wrap: `ptr`=3 after a grant to 2; requesters 0 and 3 valid → 3 is granted, then 0.
- Reset mid-WAIT: assert `rst`=0 for one edge, 5 cycles after `tx_send` → next cycle `busy`=0, `tx_send`=0, `tx_data`=8'h00; a pending request is accepted at the first edge after `rst` returns high, with grant from index 0.
- Withdrawn request and busy blocking: raise `req_valid[1]` during WAIT and drop it before WAIT ends → no `req_ready[1]`, no extra `tx_send`; `tx_data` stays constant throughout WAIT.
- Connected to the transmitter with bytes 8'h00, 8'hFF, 8'h3C sent back-to-back → the serial line shows three complete frames with the correct bit order; no send edge is missed.
